// File: rtl/joker_ep_in_buf_pkg.sv
// Shared constants and state encodings for the EP1 IN reply buffer.
package joker_ep_in_buf_pkg;

    localparam int unsigned DEF_ADDR_W  = 11;
    localparam int unsigned DEF_MAX_PKT = 64;
    localparam int unsigned DEF_ACK_CYC = 2;

    // USB data PID toggle values
    localparam logic PID_DATA0 = 1'b0;
    localparam logic PID_DATA1 = 1'b1;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ACK,
        C_LOW
    } commit_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_ARMED,
        T_SEND,
        T_WAIT
    } tx_state_t;

endpackage

// File: rtl/joker_ep_in_buf_ram.sv
// Simple dual-port byte RAM with a registered (1-cycle) read port.
module joker_ep_in_buf_ram #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];

    // Write port, contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; output register cleared by reset, held when not reading
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/joker_ep_in_buf.sv
// EP1 IN reply buffer: stores a committed reply and serves it as max-packet IN transactions.
module joker_ep_in_buf
    import joker_ep_in_buf_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned MAX_PKT = DEF_MAX_PKT,
    parameter int unsigned ACK_CYC = DEF_ACK_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_data,
    input  logic              in_wren,
    input  logic              in_commit,
    input  logic [ADDR_W-1:0] in_commit_len,
    output logic              in_commit_ack,
    output logic              in_ready,
    input  logic              tok_in,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_last,
    output logic              tx_zlp,
    input  logic              tx_ready,
    output logic              tx_data1,
    output logic              tx_nak,
    input  logic              host_ack,
    input  logic              host_tmo
);
    localparam int unsigned PKT_W = ADDR_W + 1;
    localparam int unsigned ACK_W = $clog2(ACK_CYC + 1);

    commit_state_t     c_state, c_state_n;
    logic [ACK_W-1:0]  ack_cnt, ack_cnt_n;
    logic              ack_n, accept_c;

    tx_state_t         t_state, t_state_n;
    logic [ADDR_W-1:0] len, len_n, offset, offset_n, rd_addr, rd_addr_n;
    logic [PKT_W-1:0]  pkt_len, pkt_len_n, remain, remain_n;
    logic              valid_n, last_n, zlp_n, data1_n, nak_n, ready_n;
    logic              rd_en_c, wr_en_c;
    logic [ADDR_W-1:0] rem_len_c;
    logic [PKT_W-1:0]  pkt_next_c;

    assign wr_en_c    = in_wren && in_ready;
    assign rem_len_c  = len - offset;
    assign pkt_next_c = (PKT_W'(rem_len_c) >= PKT_W'(MAX_PKT)) ? PKT_W'(MAX_PKT)
                                                              : PKT_W'(rem_len_c);

    joker_ep_in_buf_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_c),
        .wr_addr (in_addr),
        .wr_data (in_data),
        .rd_en   (rd_en_c),
        .rd_addr (rd_addr),
        .rd_data (tx_data)
    );

    // Commit handshake: accept once, hold ack for ACK_CYC cycles, then wait for the request to drop
    always_comb begin
        c_state_n = c_state;
        ack_cnt_n = ack_cnt;
        ack_n     = 1'b0;
        accept_c  = 1'b0;
        case (c_state)
            C_IDLE: begin
                if (in_commit && in_ready) begin
                    accept_c  = 1'b1;
                    ack_n     = 1'b1;
                    ack_cnt_n = ACK_W'(ACK_CYC - 1);
                    c_state_n = C_ACK;
                end
            end
            C_ACK: begin
                if (ack_cnt == '0) begin
                    c_state_n = C_LOW;
                end else begin
                    ack_n     = 1'b1;
                    ack_cnt_n = ack_cnt - ACK_W'(1);
                end
            end
            C_LOW: begin
                if (!in_commit) begin
                    c_state_n = C_IDLE;
                end
            end
            default: c_state_n = C_IDLE;
        endcase
    end

    // Packet engine: split the reply into packets, stream bytes, resolve the host handshake
    always_comb begin
        t_state_n = t_state;
        len_n     = len;
        offset_n  = offset;
        rd_addr_n = rd_addr;
        pkt_len_n = pkt_len;
        remain_n  = remain;
        valid_n   = tx_valid;
        last_n    = tx_last;
        zlp_n     = tx_zlp;
        data1_n   = tx_data1;
        nak_n     = 1'b0;
        ready_n   = in_ready;
        rd_en_c   = 1'b0;
        if (accept_c) begin
            len_n    = in_commit_len;
            offset_n = '0;
            ready_n  = 1'b0;
        end
        case (t_state)
            T_IDLE: begin
                nak_n = tok_in;
                if (accept_c) begin
                    t_state_n = T_ARMED;
                end
            end
            T_ARMED: begin
                if (tok_in) begin
                    pkt_len_n = pkt_next_c;
                    remain_n  = pkt_next_c;
                    rd_addr_n = offset;
                    t_state_n = T_SEND;
                end
            end
            T_SEND: begin
                if (!tx_valid) begin
                    // first beat: either a ZLP marker or the first RAM read
                    valid_n = 1'b1;
                    if (remain == '0) begin
                        last_n = 1'b1;
                        zlp_n  = 1'b1;
                    end else begin
                        rd_en_c   = 1'b1;
                        last_n    = (remain == PKT_W'(1));
                        remain_n  = remain - PKT_W'(1);
                        rd_addr_n = rd_addr + ADDR_W'(1);
                    end
                end else if (tx_ready) begin
                    if (tx_last) begin
                        valid_n   = 1'b0;
                        last_n    = 1'b0;
                        zlp_n     = 1'b0;
                        t_state_n = T_WAIT;
                    end else begin
                        rd_en_c   = 1'b1;
                        last_n    = (remain == PKT_W'(1));
                        remain_n  = remain - PKT_W'(1);
                        rd_addr_n = rd_addr + ADDR_W'(1);
                    end
                end
            end
            T_WAIT: begin
                if (host_ack) begin
                    offset_n = offset + ADDR_W'(pkt_len);
                    data1_n  = (tx_data1 == PID_DATA0) ? PID_DATA1 : PID_DATA0;
                    // a full packet always needs a follow-up (more data or trailing ZLP)
                    if (pkt_len != PKT_W'(MAX_PKT)) begin
                        ready_n   = 1'b1;
                        t_state_n = T_IDLE;
                    end else begin
                        t_state_n = T_ARMED;
                    end
                end else if (host_tmo) begin
                    t_state_n = T_ARMED;
                end
            end
            default: t_state_n = T_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            c_state       <= C_IDLE;
            ack_cnt       <= '0;
            in_commit_ack <= 1'b0;
            t_state       <= T_IDLE;
            len           <= '0;
            offset        <= '0;
            rd_addr       <= '0;
            pkt_len       <= '0;
            remain        <= '0;
            tx_valid      <= 1'b0;
            tx_last       <= 1'b0;
            tx_zlp        <= 1'b0;
            tx_data1      <= PID_DATA0;
            tx_nak        <= 1'b0;
            in_ready      <= 1'b1;
        end else begin
            c_state       <= c_state_n;
            ack_cnt       <= ack_cnt_n;
            in_commit_ack <= ack_n;
            t_state       <= t_state_n;
            len           <= len_n;
            offset        <= offset_n;
            rd_addr       <= rd_addr_n;
            pkt_len       <= pkt_len_n;
            remain        <= remain_n;
            tx_valid      <= valid_n;
            tx_last       <= last_n;
            tx_zlp        <= zlp_n;
            tx_data1      <= data1_n;
            tx_nak        <= nak_n;
            in_ready      <= ready_n;
        end
    end

endmodule
